// File: rtl/gate_truth_table_prober_if.sv
// Bundle of control, result and gate-side signals for gate_truth_table_prober.
// The prober is the slave; the requester/gate harness side is the master.
interface gate_truth_table_prober_if;
    logic       start;
    logic [2:0] exp_id;
    logic       dut_c;
    logic       drv_a;
    logic       drv_b;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_id;
    logic       unstable;
    logic       pass;
    logic [1:0] state_dbg;

    // start is a request that is taken whenever the prober can begin a run
    // (IDLE, or the DONE cycle); busy/done report progress, and results are
    // valid from the done pulse until the next done pulse.
    modport master (
        output start, exp_id, dut_c,
        input  drv_a, drv_b, busy, done, truth_table, gate_id, unstable, pass, state_dbg
    );

    modport slave (
        input  start, exp_id, dut_c,
        output drv_a, drv_b, busy, done, truth_table, gate_id, unstable, pass, state_dbg
    );
endinterface

// File: rtl/gate_truth_table_prober.sv
// Drives a two-input gate through all four input vectors, double-samples its
// output per vector, and reports the truth table, decoded identity and pass.
module gate_truth_table_prober #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    gate_truth_table_prober_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] FIRST_CNT  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SECOND_CNT = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic [1:0] vec_q;
    logic       s0_q;
    logic [3:0] shadow_q;
    logic       unst_acc_q;
    logic [2:0] exp_q;

    logic       drv_a_q, drv_b_q, busy_q, done_q;
    logic [3:0] tt_q;
    logic [2:0] id_q;
    logic       unstable_q, pass_q;

    logic       accept;
    logic       first_hit;
    logic       second_hit;
    logic       last_vec;
    logic [1:0] vec_inc;
    logic [3:0] shadow_next;
    logic       unst_next;
    logic [2:0] id_next;
    logic       pass_next;

    function automatic logic [2:0] decode(input logic [3:0] tt);
        logic [2:0] id;
        case (tt)
            4'b1000: id = 3'd1;
            4'b1110: id = 3'd2;
            4'b0110: id = 3'd3;
            4'b0001: id = 3'd4;
            4'b0111: id = 3'd5;
            4'b1001: id = 3'd6;
            4'b0011: id = 3'd7;
            default: id = 3'd0;
        endcase
        return id;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // The DONE cycle also takes start, so a held start chains runs back to
    // back with no idle cycle in between.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        first_hit  = 1'b0;
        second_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                first_hit  = (cnt_q == FIRST_CNT);
                second_hit = (cnt_q == SECOND_CNT);
                if (second_hit && vec_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Final-edge view of the results, so they can be loaded as DONE begins.
    always_comb begin
        last_vec           = (vec_q == 2'd3);
        vec_inc            = vec_q + 2'd1;
        shadow_next        = shadow_q;
        shadow_next[vec_q] = bus.dut_c;
        unst_next          = unst_acc_q | (bus.dut_c != s0_q);
        id_next            = unst_next ? 3'd0 : decode(shadow_next);
        pass_next          = !unst_next && (id_next != 3'd0) && (id_next == exp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 8'd0;
            vec_q      <= 2'd0;
            s0_q       <= 1'b0;
            shadow_q   <= 4'd0;
            unst_acc_q <= 1'b0;
            exp_q      <= 3'd0;
            drv_a_q    <= 1'b0;
            drv_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_q       <= 4'd0;
            id_q       <= 3'd0;
            unstable_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cnt_q      <= 8'd0;
                vec_q      <= 2'd0;
                shadow_q   <= 4'd0;
                unst_acc_q <= 1'b0;
                exp_q      <= bus.exp_id;
                drv_a_q    <= 1'b0;
                drv_b_q    <= 1'b0;
                busy_q     <= 1'b1;
            end else if (state_q == DRIVE) begin
                cnt_q <= cnt_q + 8'd1;
                if (first_hit) s0_q <= bus.dut_c;
                if (second_hit) begin
                    shadow_q   <= shadow_next;
                    unst_acc_q <= unst_next;
                    if (!last_vec) begin
                        vec_q   <= vec_inc;
                        cnt_q   <= 8'd0;
                        drv_a_q <= vec_inc[1];
                        drv_b_q <= vec_inc[0];
                    end else begin
                        drv_a_q    <= 1'b0;
                        drv_b_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        tt_q       <= shadow_next;
                        id_q       <= id_next;
                        unstable_q <= unst_next;
                        pass_q     <= pass_next;
                    end
                end
            end
        end
    end

    assign bus.drv_a       = drv_a_q;
    assign bus.drv_b       = drv_b_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = tt_q;
    assign bus.gate_id     = id_q;
    assign bus.unstable    = unstable_q;
    assign bus.pass        = pass_q;
    assign bus.state_dbg   = state_q;

endmodule
